macc_mch: RTL
=============

# macc_mch

Multi-channel, parametrised successor to the neuron multiply-accumulate. Each valid beat carries PARALLEL_IN products that are summed and accumulated into one of CHANNELS independent accumulators, so several neurons can be time-multiplexed through one datapath. Each dot product gets a per-packet bias, saturating accumulation, a saturating output cast and an optional ReLU. It sits between the weight/activation streamers and the next layer's input buffer.

## Interface
- PARALLEL_IN, 4, lanes per beat; power of two, ≥1
- DATA1_WIDTH, 16, lane width of din1 (signed)
- DATA1_INT, 2, integer bits of din1
- DATA2_WIDTH, 16, lane width of din2 (signed)
- DATA2_INT, 2, integer bits of din2
- BIAS_WIDTH, 16, bias width (signed)
- BIAS_INT, 4, bias integer bits
- ACC_WIDTH, 40, accumulator width; fraction = FA = (DATA1_WIDTH-DATA1_INT)+(DATA2_WIDTH-DATA2_INT)
- CHANNELS, 4, independent accumulators; ≥1
- DOUT_WIDTH, 32, output width (signed)
- DOUT_INT, 14, output integer bits; output fraction must be ≤ FA
- RELU, 0, 1 = clamp negative results to 0

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- din1  in  PARALLEL_IN*DATA1_WIDTH  lane i at bits [i*DATA1_WIDTH +: DATA1_WIDTH]
- din2  in  PARALLEL_IN*DATA2_WIDTH  same packing
- bias  in  BIAS_WIDTH  sampled only on the first beat of a packet
- din_ch  in  max(1,$clog2(CHANNELS))  target channel
- din_valid  in  1  beat qualifier
- last  in  1  final beat of the packet for din_ch
- dout  out  DOUT_WIDTH  result
- dout_ch  out  max(1,$clog2(CHANNELS))  channel of dout
- dout_valid  out  1  one-cycle pulse per finished packet
- dout_ovf  out  1  saturation occurred in this packet; qualified by dout_valid

## Operation
- Stage 1: register the PARALLEL_IN signed products (DATA1_WIDTH+DATA2_WIDTH bits each, fraction FA), together with bias, din_ch, last and din_valid.
- Stage 2: register the full-precision adder-tree sum, DATA1_WIDTH+DATA2_WIDTH+$clog2(PARALLEL_IN) bits. The tree never overflows.
- Stage 3: per-channel read-modify-write.
  - open[c] flag per channel; 0 means no packet in progress.
  - If open[c]=0: acc[c] = bias_aligned + sum, where the bias is sign-extended and left-shifted by FA-(BIAS_WIDTH-BIAS_INT).
  - Otherwise: acc[c] = acc[c] + sum.
  - The addition saturates to ACC_WIDTH signed limits.
  - Any saturation sets ovf[c]. ovf[c] is cleared when a new packet opens on channel c.
  - After a non-last beat, open[c] = 1.
  - On the last beat, the output is produced from the new acc value, and open[c] and ovf[c] are cleared.
- Output cast:
  - Drop FA-(DOUT_WIDTH-DOUT_INT) fraction bits by truncation (floor).
  - Saturate to DOUT_WIDTH. Cast saturation also sets dout_ovf.
  - Then apply ReLU if RELU=1. A negative result becomes 0 and does not set ovf.
- A beat with din_valid=0 has no effect, whatever the other inputs are.
- A beat with din_ch ≥ CHANNELS is dropped and produces no output.
- A single-beat packet (first beat and last together) outputs bias + sum.
- Interleaving across channels is allowed on any cycle boundary.
- Consecutive beats on the same channel carry no hazard, because acc is read and written only in stage 3.
- There is no backpressure; the block accepts one beat every cycle.

## Timing
- Latency: a last beat sampled at rising edge t gives dout, dout_ch, dout_valid and dout_ovf registered at edge t+3.
- dout_valid is high for exactly one cycle per last beat.
- Full throughput: one result per cycle is possible, for example by sending single-beat packets on alternating channels.
- dout holds its value between pulses.
- Reset (rst=0) clears immediately, regardless of clk: all pipeline valids, acc[*], open[*] and ovf[*] go to 0, and dout, dout_ch, dout_valid and dout_ovf go to 0.
- Reset mid-packet discards that packet with no output. The first valid beat after reset release opens a fresh packet and uses its bias.
- Beats in flight when reset asserts are lost.

## Test plan
- Basic packet: defaults, ch0, 3 beats, all din1 = 0x4000 (1.0), din2 = 0x2000 (0.5), bias = 0, last on beat 3 -> single dout_valid 3 cycles after beat 3, dout = 0x00180000 (6.0), dout_ch = 0, dout_ovf = 0.
- Bias plus interleave: ch1 bias 0x1000 (1.0) and ch2 bias 0xF000 (-1.0) alternate beats, each 2 beats of sum 2.0 -> ch1 dout 5.0 (0x00140000), then ch2 dout 3.0 (0x000C0000), one cycle apart.
- ReLU: RELU=1, single beat din1 = 0xC000 (-1.0), din2 = 0x4000, bias 0 -> dout = 0; with RELU=0 -> dout = -4.0 (0xFFF00000).
- Saturation: DOUT_INT=4 override, 4 beats of sum 4.0 (total 16.0) -> dout = 0x7FFFFFFF, dout_ovf = 1. The next packet on the same channel reports dout_ovf = 0.
- Reset mid-packet: 2 beats on ch0, then rst low for 1 cycle, then 1 beat sum 2.0 with last and bias 0 -> the only dout_valid carries 2.0 (0x00080000). Asserting rst drives all outputs to 0 without a clock edge.
- Illegal channel / idle: CHANNELS=3, beat with din_ch = 3 and last -> no dout_valid. din_valid = 0 with last = 1 -> no dout_valid and no accumulator change.

Source files
------------

// File: rtl/macc_mch.sv
// Multi-channel multiply-accumulate: PARALLEL_IN products per beat are summed and
// accumulated per channel with per-packet bias, saturation, output cast and optional ReLU.
module macc_mch #(
    parameter int PARALLEL_IN = 4,
    parameter int DATA1_WIDTH = 16,
    parameter int DATA1_INT   = 2,
    parameter int DATA2_WIDTH = 16,
    parameter int DATA2_INT   = 2,
    parameter int BIAS_WIDTH  = 16,
    parameter int BIAS_INT    = 4,
    parameter int ACC_WIDTH   = 40,
    parameter int CHANNELS    = 4,
    parameter int DOUT_WIDTH  = 32,
    parameter int DOUT_INT    = 14,
    parameter int RELU        = 0,
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [PARALLEL_IN*DATA1_WIDTH-1:0] din1,
    input  logic [PARALLEL_IN*DATA2_WIDTH-1:0] din2,
    input  logic [BIAS_WIDTH-1:0]              bias,
    input  logic [CHW-1:0]                     din_ch,
    input  logic                               din_valid,
    input  logic                               last,
    output logic [DOUT_WIDTH-1:0]              dout,
    output logic [CHW-1:0]                     dout_ch,
    output logic                               dout_valid,
    output logic                               dout_ovf
);

    localparam int FA         = (DATA1_WIDTH - DATA1_INT) + (DATA2_WIDTH - DATA2_INT);
    localparam int PW         = DATA1_WIDTH + DATA2_WIDTH;
    localparam int SW         = PW + $clog2(PARALLEL_IN);
    localparam int BIAS_SHIFT = FA - (BIAS_WIDTH - BIAS_INT);
    localparam int OUT_SHIFT  = FA - (DOUT_WIDTH - DOUT_INT);
    localparam int AW1        = ACC_WIDTH + 1;
    localparam int CW         = ((ACC_WIDTH > DOUT_WIDTH) ? ACC_WIDTH : DOUT_WIDTH) + 1;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [CW-1:0] DOUT_MAX_W = {{(CW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [CW-1:0] DOUT_MIN_W = {{(CW-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

    // Stage 1: lane products
    logic signed [PW-1:0]         prod_d   [PARALLEL_IN];
    logic signed [PW-1:0]         s1_prod_q[PARALLEL_IN];
    logic signed [BIAS_WIDTH-1:0] s1_bias_q;
    logic [CHW-1:0]               s1_ch_q;
    logic                         s1_last_q;
    logic                         s1_valid_q, s1_valid_d;
    logic [31:0]                  ch_ext;

    // Stage 2: adder tree
    logic signed [SW-1:0]         sum_d, s2_sum_q;
    logic signed [BIAS_WIDTH-1:0] s2_bias_q;
    logic [CHW-1:0]               s2_ch_q;
    logic                         s2_last_q;
    logic                         s2_valid_q;

    // Stage 3: per-channel accumulators
    logic signed [ACC_WIDTH-1:0]  acc_q [CHANNELS];
    logic signed [ACC_WIDTH-1:0]  acc_d [CHANNELS];
    logic [CHANNELS-1:0]          open_q, open_d;
    logic [CHANNELS-1:0]          ovf_q, ovf_d;
    logic signed [ACC_WIDTH-1:0]  bias_al, acc_base, acc_new;
    logic signed [AW1-1:0]        acc_wide;
    logic                         acc_sat, ovf_new;
    logic signed [ACC_WIDTH-1:0]  r3_acc_q;
    logic [CHW-1:0]               r3_ch_q;
    logic                         r3_ovf_q;
    logic                         r3_valid_q;

    // Output cast
    logic signed [ACC_WIDTH-1:0]  out_shifted;
    logic signed [CW-1:0]         out_wide;
    logic                         out_sat;
    logic [DOUT_WIDTH-1:0]        out_cast, out_res;
    logic [DOUT_WIDTH-1:0]        dout_q, dout_d;
    logic [CHW-1:0]               dout_ch_q, dout_ch_d;
    logic                         dout_valid_q;
    logic                         dout_ovf_q, dout_ovf_d;

    // Out-of-range channels never enter the pipeline.
    always_comb begin
        ch_ext     = 32'(din_ch);
        s1_valid_d = din_valid && (ch_ext < 32'(CHANNELS));
        for (int i = 0; i < PARALLEL_IN; i++) begin
            prod_d[i] = PW'($signed(din1[i*DATA1_WIDTH +: DATA1_WIDTH]))
                      * PW'($signed(din2[i*DATA2_WIDTH +: DATA2_WIDTH]));
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < PARALLEL_IN; i++) begin
            sum_d = sum_d + SW'(s1_prod_q[i]);
        end
    end

    // A closed channel starts from the aligned bias instead of the stale accumulator.
    always_comb begin
        bias_al  = ACC_WIDTH'(s2_bias_q) <<< BIAS_SHIFT;
        acc_base = open_q[s2_ch_q] ? acc_q[s2_ch_q] : bias_al;
        acc_wide = AW1'(acc_base) + AW1'(s2_sum_q);
        acc_sat  = acc_wide[AW1-1] != acc_wide[AW1-2];
        if (acc_sat) begin
            acc_new = acc_wide[AW1-1] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_new = acc_wide[ACC_WIDTH-1:0];
        end
        ovf_new = (open_q[s2_ch_q] && ovf_q[s2_ch_q]) || acc_sat;

        acc_d  = acc_q;
        open_d = open_q;
        ovf_d  = ovf_q;
        if (s2_valid_q) begin
            acc_d[s2_ch_q]  = acc_new;
            open_d[s2_ch_q] = !s2_last_q;
            ovf_d[s2_ch_q]  = s2_last_q ? 1'b0 : ovf_new;
        end
    end

    always_comb begin
        out_shifted = r3_acc_q >>> OUT_SHIFT;
        out_wide    = CW'(out_shifted);
        out_sat     = (out_wide > DOUT_MAX_W) || (out_wide < DOUT_MIN_W);
        if (out_sat) begin
            out_cast = out_wide[CW-1] ? DOUT_MIN_W[DOUT_WIDTH-1:0] : DOUT_MAX_W[DOUT_WIDTH-1:0];
        end else begin
            out_cast = out_wide[DOUT_WIDTH-1:0];
        end
        out_res = out_cast;
        if ((RELU != 0) && out_cast[DOUT_WIDTH-1]) begin
            out_res = '0;
        end

        dout_d     = dout_q;
        dout_ch_d  = dout_ch_q;
        dout_ovf_d = dout_ovf_q;
        if (r3_valid_q) begin
            dout_d     = out_res;
            dout_ch_d  = r3_ch_q;
            dout_ovf_d = r3_ovf_q || out_sat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PARALLEL_IN; i++) begin
                s1_prod_q[i] <= '0;
            end
            s1_bias_q    <= '0;
            s1_ch_q      <= '0;
            s1_last_q    <= 1'b0;
            s1_valid_q   <= 1'b0;
            s2_sum_q     <= '0;
            s2_bias_q    <= '0;
            s2_ch_q      <= '0;
            s2_last_q    <= 1'b0;
            s2_valid_q   <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                acc_q[c] <= '0;
            end
            open_q       <= '0;
            ovf_q        <= '0;
            r3_acc_q     <= '0;
            r3_ch_q      <= '0;
            r3_ovf_q     <= 1'b0;
            r3_valid_q   <= 1'b0;
            dout_q       <= '0;
            dout_ch_q    <= '0;
            dout_valid_q <= 1'b0;
            dout_ovf_q   <= 1'b0;
        end else begin
            s1_prod_q    <= prod_d;
            s1_bias_q    <= $signed(bias);
            s1_ch_q      <= din_ch;
            s1_last_q    <= last;
            s1_valid_q   <= s1_valid_d;
            s2_sum_q     <= sum_d;
            s2_bias_q    <= s1_bias_q;
            s2_ch_q      <= s1_ch_q;
            s2_last_q    <= s1_last_q;
            s2_valid_q   <= s1_valid_q;
            acc_q        <= acc_d;
            open_q       <= open_d;
            ovf_q        <= ovf_d;
            r3_acc_q     <= acc_new;
            r3_ch_q      <= s2_ch_q;
            r3_ovf_q     <= ovf_new;
            r3_valid_q   <= s2_valid_q && s2_last_q;
            dout_q       <= dout_d;
            dout_ch_q    <= dout_ch_d;
            dout_valid_q <= r3_valid_q;
            dout_ovf_q   <= dout_ovf_d;
        end
    end

    assign dout       = dout_q;
    assign dout_ch    = dout_ch_q;
    assign dout_valid = dout_valid_q;
    assign dout_ovf   = dout_ovf_q;

endmodule
